hex_scan_controller: RTL and testbench
======================================

Name: hex_scan_controller

Overview:
- Time-multiplexed digit scanner that sits directly upstream of the hex-to-7-segment decoder.
- Latches a DIGITS-nibble value and presents one 4-bit nibble at a time on Nibble, which feeds the decoder.
- Drives one-hot active-low digit enables, with a dead-time gap between digits to prevent ghosting.
- New values reach the display only at frame boundaries, so no digit shows a mix of old and new data.

Parameters:
- DIGITS, 4, number of multiplexed digits (1-8).
- SCAN_DIV, 50000, clock cycles per digit slot (1 ms at 50 MHz); must be greater than GAP_CYC.
- GAP_CYC, 500, dead-time cycles at the start of each slot with all digits disabled; must be 1 or more.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- Load  input  1  one-cycle strobe; captures Data into the shadow register.
- Data  input  4*DIGITS  value to display; nibble i is shown on digit i, nibble 0 is least significant.
- Nibble  output  4  nibble of the currently enabled digit; goes to the decoder's In.
- DigitSel  output  DIGITS  active-low one-hot digit enable; all ones during gap.
- Blank  output  1  high while in the gap or while all digits are disabled.
- FramePulse  output  1  one-cycle pulse when the digit index wraps to 0.

Behaviour:
- Single clock domain; all outputs are registered.
- Reset values:
  - slot counter 0, digit index 0, state S_GAP;
  - shadow and display registers 0;
  - Nibble 0, DigitSel all ones, Blank 1, FramePulse 0.
- Slot counter counts 0..SCAN_DIV-1 and wraps.
  - Count < GAP_CYC: state S_GAP.
  - Otherwise: state S_SHOW.
- Output registers load from the next-state values.
  - Example with SCAN_DIV=8, GAP_CYC=2: DigitSel[0] goes low after the 2nd rising edge with Reset low and stays low 6 cycles.
- S_GAP: DigitSel = all ones, Blank = 1, Nibble holds its previous value.
- S_SHOW: DigitSel[idx] = 0, all other bits 1; Nibble = display[4*idx+3 : 4*idx]; Blank = 0.
- Slot wrap: idx increments modulo DIGITS.
  - When idx wraps DIGITS-1 -> 0, FramePulse = 1 for exactly that cycle.
  - On that same cycle, the display register loads from the shadow register.
- Load = 1: shadow register captures Data on that edge.
  - Multiple Loads within one frame: the last one wins.
- Load coincident with the frame-boundary edge: Data goes directly into both shadow and display registers; there is no one-frame lag.
- DIGITS = 1: idx stays 0; FramePulse fires on every slot wrap.
- Reset mid-scan: all state returns to reset values on the next edge; the scan restarts at digit 0 in gap.
- DigitSel never has more than one bit low. The gap guarantees at least GAP_CYC cycles between any two distinct enables.

Optional Feature:
- Macro: HEX_SCAN_LZB_EN, leading-zero blanking.
- Defined:
  - Digits above the most significant nonzero nibble of the display register are blank: DigitSel bit held 1, Blank = 1 during their S_SHOW slot.
  - Digit 0 is always shown, so value 0 displays as a single "0".
  - Slot timing and FramePulse are unchanged.
- Undefined: all digits are shown, including leading zeros.

Decomposition:
- Package hex_scan_pkg holds:
  - typedef enum logic {S_GAP, S_SHOW} scan_state_t;
  - localparams DEF_SCAN_DIV = 50000 and DEF_GAP_CYC = 500;
  - function msd_index(value, digits), returning the leading-nonzero nibble index (used only under HEX_SCAN_LZB_EN).
- Sub-module scan_prescaler:
  - contains the slot counter;
  - outputs in_gap and slot_end;
  - parameterised by SCAN_DIV and GAP_CYC.
- The top module holds the digit index, shadow/display registers and output registers.
- Decoder instances live in the parent, not in this block.

Test Plan (DIGITS=4, SCAN_DIV=8, GAP_CYC=2 unless noted):
- Reset 3 cycles, release, Load Data=16'h1A3F → first frame all zeros. Starting at the next frame, the sequence is: digit 0 shows F, digit 1 shows 3, digit 2 shows A, digit 3 shows 1. Each digit is enabled 6 cycles and separated by 2 cycles with DigitSel=4'b1111.
- Free-run 100 cycles → FramePulse period exactly 32 cycles, width 1. DigitSel is always one-hot-low or all ones.
- Loads 16'h1111 then 16'h2222 within one frame → next frame shows only 2s. No frame mixes 1s and 2s.
- Load 16'hBEEF asserted on the exact frame-boundary cycle → that same new frame shows F,E,E,B.
- Reset asserted while digit 2 is enabled → next cycle: DigitSel=4'b1111, Nibble=0, Blank=1. The scan resumes at digit 0 after release.
- With HEX_SCAN_LZB_EN, Data=16'h0042 → digits 2 and 3 are never enabled; digits 0 and 1 show 2 and 4. Data=16'h0000 → only digit 0 is enabled, showing 0.

Source files
------------

// File: rtl/hex_scan_pkg.sv
// hex_scan_pkg: shared types, default timing constants and helpers for the
// hex digit scanner.
//   scan_state_t : slot phase (dead-time gap or digit shown)
//   DEF_SCAN_DIV : default clock cycles per digit slot
//   DEF_GAP_CYC  : default dead-time cycles at the start of each slot
//   msd_index()  : index of the most significant nonzero nibble, 0 if none
//                  (used only when HEX_SCAN_LZB_EN is defined)
package hex_scan_pkg;

  typedef enum logic {S_GAP, S_SHOW} scan_state_t;

  localparam int unsigned DEF_SCAN_DIV = 50000;
  localparam int unsigned DEF_GAP_CYC  = 500;

  // Scans up to 8 nibbles; nibbles at or above 'digits' are ignored.
  function automatic int unsigned msd_index(input logic [31:0] value,
                                            input int unsigned digits);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < digits && value[4*i +: 4] != 4'h0) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/hex_scan_controller_prescaler.sv
// scan_prescaler: digit-slot timer for the hex scanner.
//   clk, reset : system clock, synchronous active-high reset
//   in_gap     : the slot position reached on the next edge is inside the
//                dead-time gap (count < GAP_CYC)
//   slot_end   : current count is the last cycle of the slot (SCAN_DIV-1)
module scan_prescaler
  import hex_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = DEF_SCAN_DIV,
  parameter int unsigned GAP_CYC  = DEF_GAP_CYC
) (
  input  logic clk,
  input  logic reset,
  output logic in_gap,
  output logic slot_end
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // in_gap looks at the next count so the top can register its outputs
  // from next-state values and have them line up with the counter.
  always_comb begin
    slot_end = (cnt == CNT_W'(SCAN_DIV - 1));
    cnt_next = slot_end ? '0 : cnt + 1'b1;
    in_gap   = (cnt_next < CNT_W'(GAP_CYC));
  end

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_next;
  end

endmodule

// File: rtl/hex_scan_controller.sv
// hex_scan_controller: time-multiplexed digit scanner feeding a
// hex-to-7-segment decoder.
//   Clk, Reset : system clock, synchronous active-high reset
//   Load       : one-cycle strobe, captures Data into the shadow register
//   Data       : 4*DIGITS value, nibble i shown on digit i
//   Nibble     : nibble of the enabled digit (decoder input)
//   DigitSel   : active-low one-hot digit enable, all ones during the gap
//   Blank      : high during the gap or while no digit is enabled
//   FramePulse : one-cycle pulse as the digit index wraps to 0
// Optional: define HEX_SCAN_LZB_EN for leading-zero blanking.
module hex_scan_controller
  import hex_scan_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = DEF_SCAN_DIV,
  parameter int unsigned GAP_CYC  = DEF_GAP_CYC
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Data,
  output logic [3:0]            Nibble,
  output logic [DIGITS-1:0]     DigitSel,
  output logic                  Blank,
  output logic                  FramePulse
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                in_gap;
  logic                slot_end;
  logic                frame_wrap;
  logic                visible;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_next;
  logic [4*DIGITS-1:0] shadow;
  logic [4*DIGITS-1:0] display;
  logic [4*DIGITS-1:0] display_next;
  scan_state_t         state;
  scan_state_t         state_next;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV),
    .GAP_CYC  (GAP_CYC)
  ) u_prescaler (
    .clk      (Clk),
    .reset    (Reset),
    .in_gap   (in_gap),
    .slot_end (slot_end)
  );

  always_comb begin
    frame_wrap = slot_end && (idx == IDX_W'(DIGITS - 1));

    idx_next = idx;
    if (slot_end) idx_next = frame_wrap ? '0 : idx + 1'b1;

    // A Load on the frame-boundary edge bypasses the shadow so the new
    // value is shown in the frame that starts right now.
    display_next = display;
    if (frame_wrap) display_next = Load ? Data : shadow;

    state_next = in_gap ? S_GAP : S_SHOW;

`ifdef HEX_SCAN_LZB_EN
    visible = (int unsigned'(idx_next) <= msd_index(32'(display_next), DIGITS));
`else
    visible = 1'b1;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx        <= '0;
      shadow     <= '0;
      display    <= '0;
      state      <= S_GAP;
      Nibble     <= 4'h0;
      DigitSel   <= '1;
      Blank      <= 1'b1;
      FramePulse <= 1'b0;
    end else begin
      if (Load) shadow <= Data;
      display    <= display_next;
      idx        <= idx_next;
      state      <= state_next;
      FramePulse <= frame_wrap;
      // Outputs come from next-state values so they change on the same
      // edge as the slot counter; Nibble holds through gaps and blanked slots.
      if (state_next == S_SHOW && visible) begin
        DigitSel <= ~(DIGITS'(1) << idx_next);
        Nibble   <= display_next[4*idx_next +: 4];
        Blank    <= 1'b0;
      end else begin
        DigitSel <= '1;
        Blank    <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      assert (state == S_SHOW || DigitSel == '1)
        else $error("digit enabled during gap");
    end
  end

endmodule

// File: tb/tb_hex_scan_controller.sv
// tb_hex_scan_controller: directed bench for hex_scan_controller with
// DIGITS=4, SCAN_DIV=8, GAP_CYC=2 (32-cycle frame). n counts rising edges
// since reset release; each slot is 8 edges: 2 gap, 6 digit shown.
// Honours HEX_SCAN_LZB_EN when the design is built with it.
module tb_hex_scan_controller;

  logic        Clk;
  logic        Reset;
  logic        Load;
  logic [15:0] Data;
  logic [3:0]  Nibble;
  logic [3:0]  DigitSel;
  logic        Blank;
  logic        FramePulse;

  int          tests = 0;
  int          fails = 0;
  int          n     = 0;
  logic [3:0]  prev_nib;

  hex_scan_controller #(
    .DIGITS   (4),
    .SCAN_DIV (8),
    .GAP_CYC  (2)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Load       (Load),
    .Data       (Data),
    .Nibble     (Nibble),
    .DigitSel   (DigitSel),
    .Blank      (Blank),
    .FramePulse (FramePulse)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp)
      else begin
        fails++;
        $error("FAIL %s n=%0d got %h exp %h", tag, n, got, exp);
      end
  endtask

`ifdef HEX_SCAN_LZB_EN
  function automatic int top_nz(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] != 4'h0) r = i;
    return r;
  endfunction
`endif

  // Expected outputs after edge n given the value the display holds.
  task automatic check_slot(input logic [15:0] val);
    int         ph;
    int         d;
    logic       shown;
    logic [3:0] e_ds;
    logic [3:0] e_nib;
    ph    = n % 8;
    d     = (n / 8) % 4;
    shown = (ph >= 2);
`ifdef HEX_SCAN_LZB_EN
    if (d > top_nz(val)) shown = 1'b0;
`endif
    e_ds  = shown ? ~(4'b0001 << d) : 4'b1111;
    e_nib = shown ? val[4*d +: 4] : prev_nib;
    prev_nib = e_nib;
    chk("digitsel", 16'(DigitSel), 16'(e_ds));
    chk("blank", 16'(Blank), 16'(!shown));
    chk("nibble", 16'(Nibble), 16'(e_nib));
    chk("framepulse", 16'(FramePulse), 16'((n % 32 == 0) && (n != 0)));
  endtask

  task automatic tick_check(input logic [15:0] val);
    @(posedge Clk);
    #1;
    n++;
    check_slot(val);
  endtask

  task automatic run_to(input int last, input logic [15:0] val);
    while (n < last) tick_check(val);
  endtask

  task automatic load_step(input logic [15:0] d, input logic [15:0] val);
    Load = 1'b1;
    Data = d;
    tick_check(val);
    Load = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_digitsel", 16'(DigitSel), 16'hF);
    chk("rst_nibble", 16'(Nibble), 16'h0);
    chk("rst_blank", 16'(Blank), 16'h1);
    chk("rst_framepulse", 16'(FramePulse), 16'h0);
  endtask

  initial begin
    Reset    = 1'b1;
    Load     = 1'b0;
    Data     = 16'h0000;
    prev_nib = 4'h0;
    repeat (3) @(posedge Clk);
    #1;
    check_reset_state();
    Reset = 1'b0;
    n     = 0;

    // First frame shows zeros; 1A3F appears from the next frame on.
    load_step(16'h1A3F, 16'h0000);
    run_to(31, 16'h0000);
    run_to(72, 16'h1A3F);

    // Two loads in one frame: only the last reaches the display.
    load_step(16'h1111, 16'h1A3F);
    run_to(80, 16'h1A3F);
    load_step(16'h2222, 16'h1A3F);
    run_to(95, 16'h1A3F);
    run_to(127, 16'h2222);

    // Load on the frame-boundary edge goes straight to the display.
    load_step(16'hBEEF, 16'hBEEF);
    run_to(179, 16'hBEEF);
    chk("pre_reset_dig2", 16'(DigitSel), 16'hB);

    // Reset while digit 2 is enabled.
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check_reset_state();
    @(posedge Clk);
    #1;
    Reset    = 1'b0;
    n        = 0;
    prev_nib = 4'h0;
    load_step(16'h5678, 16'h0000);
    run_to(31, 16'h0000);
    run_to(70, 16'h5678);

    // Leading-zero values (blanked only when the design enables it).
    load_step(16'h0042, 16'h5678);
    run_to(95, 16'h5678);
    run_to(110, 16'h0042);
    load_step(16'h0000, 16'h0042);
    run_to(127, 16'h0042);
    run_to(170, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
